// File: rtl/mips_cpu_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// memory strobes, IR/PC enables, PC source and register-file write controls.
//
// Memory handshake: a read or write strobe, once raised, is held together
// with the address select until a cycle where waitrequest=0; that cycle
// completes the transfer and the FSM advances on the next clock edge.
// Strobes are combinational from the registered state (Mealy completion),
// so they stay constant across a stall and drop as soon as rst_n goes low.
module mips_cpu_ctrl_fsm #(
    parameter bit HALT_ON_PC_ZERO = 1'b1,
    parameter int STATE_W         = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               waitrequest,
    input  logic               branch_taken,
    input  logic               pc_zero,
    output logic               active,
    output logic [STATE_W-1:0] state,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write_en,
    output logic [1:0]         reg_dst_sel
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_NONE,
        C_ALU_R,
        C_JR,
        C_JALR,
        C_ALU_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_J,
        C_JAL,
        C_ILLEGAL
    } class_e;

    state_e state_q, state_d;
    class_e class_q, class_d;
    class_e dec_class;

    logic       mem_read_c;
    logic       mem_write_c;
    logic       mem_addr_sel_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic [1:0] pc_src_c;
    logic       reg_write_en_c;

    // State and latched instruction class registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            class_q <= C_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Instruction class decode from the IR fields.
    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode) inside
            6'h00: begin
                if (funct == 6'h08)      dec_class = C_JR;
                else if (funct == 6'h09) dec_class = C_JALR;
                else                     dec_class = C_ALU_R;
            end
            6'h01, [6'h04:6'h07]: dec_class = C_BRANCH;
            6'h02:                dec_class = C_J;
            6'h03:                dec_class = C_JAL;
            [6'h08:6'h0F]:        dec_class = C_ALU_I;
            [6'h20:6'h26]:        dec_class = C_LOAD;
            6'h28, 6'h29, 6'h2B:  dec_class = C_STORE;
            default:              dec_class = C_ILLEGAL;
        endcase
    end

    // Next-state and strobe generation.
    always_comb begin
        state_d        = state_q;
        class_d        = class_q;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        pc_src_c       = 2'b00;
        reg_write_en_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (HALT_ON_PC_ZERO && pc_zero) begin
                    state_d = S_HALT;
                end else begin
                    mem_read_c = 1'b1;
                    if (!waitrequest) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                state_d = (dec_class == C_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (class_q)
                    C_BRANCH: begin
                        pc_write_c = branch_taken;
                        pc_src_c   = 2'b01;
                    end
                    C_J: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'b10;
                    end
                    C_JR: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'b11;
                    end
                    C_JAL: begin
                        pc_write_c     = 1'b1;
                        pc_src_c       = 2'b10;
                        reg_write_en_c = 1'b1;
                    end
                    C_JALR: begin
                        pc_write_c     = 1'b1;
                        pc_src_c       = 2'b11;
                        reg_write_en_c = 1'b1;
                    end
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    C_ALU_R, C_ALU_I: state_d = S_WB;
                    default:          state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_addr_sel_c = 1'b1;
                mem_read_c     = (class_q == C_LOAD);
                mem_write_c    = (class_q == C_STORE);
                if (!waitrequest) begin
                    state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write_en_c = 1'b1;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Output stage: strobes are forced low while reset is asserted so an
    // in-flight transfer is abandoned immediately.
    always_comb begin
        mem_read     = mem_read_c & rst_n;
        mem_write    = mem_write_c & rst_n;
        mem_addr_sel = mem_addr_sel_c & rst_n;
        ir_write     = ir_write_c & rst_n;
        pc_write     = pc_write_c & rst_n;
        pc_src       = rst_n ? pc_src_c : 2'b00;
        reg_write_en = reg_write_en_c & rst_n;
    end

    // Destination select follows the latched class in every state.
    always_comb begin
        case (class_q)
            C_ALU_R, C_JALR: reg_dst_sel = 2'b01;
            C_JAL:           reg_dst_sel = 2'b10;
            default:         reg_dst_sel = 2'b00;
        endcase
    end

    assign active = (state_q != S_HALT);
    assign state  = STATE_W'(state_q);

endmodule

// File: doc/mips_cpu_ctrl_fsm.md
Name: mips_cpu_ctrl_fsm

Overview:
Multicycle control sequencer for the MIPS CPU core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the memory strobes, IR/PC write enables and PC source. It also drives the register-file write enable and the 2-bit destination-select code consumed by the register-write-address mux (rt / rd / $31). It honours the memory waitrequest handshake and halts the core when execution reaches PC 0.

Parameters:
HALT_ON_PC_ZERO, 1, 1 = enter HALT when fetching from PC 0; 0 = never halt on PC 0
STATE_W, 3, width of state encoding exported on debug port

Ports:
clk  in  1  core clock, rising-edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0], valid from DECODE onward
waitrequest  in  1  memory stall; transfer completes on a cycle with strobe=1 and waitrequest=0
branch_taken  in  1  datapath branch comparison result, valid in EXEC
pc_zero  in  1  datapath PC == 0
active  out  1  core running
state  out  STATE_W  current state (debug)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  latch instruction into IR
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jump immediate, 11 register rs
reg_write_en  out  1  register-file write strobe
reg_dst_sel  out  2  00 rt, 01 rd, 1x $31

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, class register=NONE, active=1, all strobes 0, pc_src=00, reg_dst_sel=00, mem_addr_sel=0.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Instruction classes, latched in DECODE:
  - ALU_R: opcode 0x00, funct not 0x08/0x09
  - JR: opcode 0x00, funct 0x08
  - JALR: opcode 0x00, funct 0x09
  - ALU_I: opcode 0x08–0x0F
  - LOAD: opcode 0x20–0x26
  - STORE: opcode 0x28, 0x29, 0x2B
  - BRANCH: opcode 0x01, 0x04–0x07
  - J: opcode 0x02
  - JAL: opcode 0x03
  - anything else: ILLEGAL
- FETCH:
  - If HALT_ON_PC_ZERO and pc_zero: go to HALT; no strobe issued.
  - Otherwise: mem_read=1, mem_addr_sel=0.
  - While waitrequest=1: hold state, strobes stable.
  - On waitrequest=0: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
- DECODE: latch class (ILLEGAL -> HALT); otherwise go to EXEC. No strobes.
- EXEC:
  - BRANCH: pc_write=branch_taken, pc_src=01 -> FETCH.
  - J: pc_write=1, pc_src=10 -> FETCH.
  - JR: pc_write=1, pc_src=11 -> FETCH.
  - JAL: pc_write=1, pc_src=10, reg_write_en=1, reg_dst_sel=10 -> FETCH.
  - JALR: pc_write=1, pc_src=11, reg_write_en=1, reg_dst_sel=01 -> FETCH.
  - LOAD or STORE: -> MEM.
  - ALU_R or ALU_I: -> WB.
- MEM:
  - mem_addr_sel=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Hold while waitrequest=1.
  - On completion: LOAD -> WB, STORE -> FETCH.
  - mem_read and mem_write are never asserted together.
- WB: reg_write_en=1 for exactly one cycle, then -> FETCH.
  - reg_dst_sel: 01 for ALU_R; 00 for ALU_I and LOAD.
- HALT: active=0, all strobes 0; stays until reset. waitrequest is ignored.
- reg_dst_sel is driven from the latched class in every state. reg_write_en is the sole qualifier; reg_dst_sel is don't-care when reg_write_en=0.
- All strobes are combinational from state, class, waitrequest and branch_taken (registered state, Mealy completion). No strobe glitches across a waitrequest stall.
- Reset mid-transfer (FETCH or MEM with waitrequest=1): strobes drop immediately; FETCH is restarted after rst_n rises; the aborted transfer is not completed.
- Instruction latency with zero wait states:
  - BRANCH / J / JR / JAL / JALR: 3 cycles
  - ALU: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
  - Each waitrequest cycle adds 1.

Test Plan:
- Reset, then ADDU (op 0x00, funct 0x21), waitrequest=0 -> states 0,1,2,4; reg_write_en high only in WB with reg_dst_sel=01; back in FETCH at cycle 5.
- LW (op 0x23) with waitrequest=1 for 3 cycles in MEM -> mem_read=1, mem_addr_sel=1 held 4 cycles; WB reg_dst_sel=00; total 8 cycles.
- JAL (op 0x03) -> in EXEC: pc_write=1, pc_src=10, reg_write_en=1, reg_dst_sel=10; JALR (op 0x00, funct 0x09) -> pc_src=11, reg_dst_sel=01.
- BEQ (op 0x04) with branch_taken=0 then 1 -> pc_write 0 then 1 in EXEC, pc_src=01; reg_write_en never asserted.
- pc_zero=1 on entering FETCH -> no mem_read; next cycle state=5, active=0; stays halted 20 cycles despite waitrequest toggling. Opcode 0x3F -> HALT after DECODE.
- rst_n pulsed low during MEM stall of SW (op 0x2B) -> mem_write drops asynchronously; after release state=FETCH, active=1, mem_read=1.
